// File: rtl/i2c_peripheral_device.sv
// I2C target: oversampled scl/sda, START/STOP detection, 7-bit address match,
// byte receive for writes and byte transmit for reads on an open-drain sda.
module i2c_peripheral_device #(
   parameter logic [6:0] DEVICE_ADDR = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_match,
   output logic       rw_flag,
   output logic       busy
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_ADDR       = 3'd1;
   localparam logic [2:0] S_ADDR_ACK   = 3'd2;
   localparam logic [2:0] S_WRITE      = 3'd3;
   localparam logic [2:0] S_WRITE_ACK  = 3'd4;
   localparam logic [2:0] S_READ       = 3'd5;
   localparam logic [2:0] S_MASTER_ACK = 3'd6;
   localparam logic [2:0] S_WAIT_STOP  = 3'd7;

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_rise;
   logic                   scl_fall;
   logic                   start_det;
   logic                   stop_det;
   logic                   shift_en;
   logic                   load_tx;

   logic [2:0] state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic       sda_low;
   logic       ack_phase;

   // Open-drain: only ever pull low or release.
   assign sda = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

   // scl_rise needs scl low on the previous sample, so it never coincides with START/STOP.
   assign shift_en = scl_rise & ((state == S_ADDR) | (state == S_WRITE));
   assign load_tx  = scl_fall & ~start_det & ~stop_det & ack_phase &
                     (((state == S_ADDR_ACK) & rw_flag) | (state == S_MASTER_ACK));

   always_ff @(posedge clk) begin
      if (load_tx)
         shift <= tx_data;
      else if (shift_en)
         shift[bit_cnt] <= sda_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         bit_cnt    <= 3'd7;
         sda_low    <= 1'b0;
         ack_phase  <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         addr_match <= 1'b0;
         rw_flag    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         addr_match <= 1'b0;
         if (stop_det) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            sda_low   <= 1'b0;
            ack_phase <= 1'b0;
         end else if (start_det) begin
            state     <= S_ADDR;
            bit_cnt   <= 3'd7;
            sda_low   <= 1'b0;
            ack_phase <= 1'b0;
         end else begin
            case (state)
               S_ADDR: begin
                  if (scl_rise) begin
                     if (bit_cnt == 3'd0) begin
                        if (shift[7:1] == DEVICE_ADDR) begin
                           addr_match <= 1'b1;
                           rw_flag    <= sda_s;
                           busy       <= 1'b1;
                           state      <= S_ADDR_ACK;
                        end else begin
                           busy  <= 1'b0;
                           state <= S_WAIT_STOP;
                        end
                     end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_low   <= 1'b1;
                        ack_phase <= 1'b1;
                     end else begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= 3'd7;
                        if (rw_flag) begin
                           sda_low <= ~tx_data[7];
                           state   <= S_READ;
                        end else begin
                           sda_low <= 1'b0;
                           state   <= S_WRITE;
                        end
                     end
                  end
               end
               S_WRITE: begin
                  if (scl_rise) begin
                     if (bit_cnt == 3'd0) begin
                        rx_data  <= {shift[7:1], sda_s};
                        rx_valid <= 1'b1;
                        state    <= S_WRITE_ACK;
                     end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                     end
                  end
               end
               S_WRITE_ACK: begin
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_low   <= 1'b1;
                        ack_phase <= 1'b1;
                     end else begin
                        sda_low   <= 1'b0;
                        ack_phase <= 1'b0;
                        bit_cnt   <= 3'd7;
                        state     <= S_WRITE;
                     end
                  end
               end
               S_READ: begin
                  // Bit 7 was already put on the bus at the load point.
                  if (scl_fall) begin
                     if (bit_cnt == 3'd0) begin
                        sda_low <= 1'b0;
                        state   <= S_MASTER_ACK;
                     end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                        sda_low <= ~shift[bit_cnt - 3'd1];
                     end
                  end
               end
               S_MASTER_ACK: begin
                  if (scl_rise) begin
                     if (sda_s)
                        state <= S_WAIT_STOP;
                     else
                        ack_phase <= 1'b1;
                  end else if (scl_fall && ack_phase) begin
                     ack_phase <= 1'b0;
                     bit_cnt   <= 3'd7;
                     sda_low   <= ~tx_data[7];
                     state     <= S_READ;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_peripheral_device.sv
// Scoreboard bench for i2c_peripheral_device: a bus-level master drives scl/sda,
// a transaction-level model queues expected bytes/acks, and a monitor checks DUT pulses.
module tb_i2c_peripheral_device;

   localparam logic [6:0] DEV = 7'h42;
   localparam int         Q   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       addr_match;
   logic       rw_flag;
   logic       busy;
   wire        sda_bus;

   pullup (sda_bus);
   assign sda_bus = m_low ? 1'b0 : 1'bz;

   i2c_peripheral_device #(.DEVICE_ADDR(DEV), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus), .tx_data(tx_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .addr_match(addr_match),
      .rw_flag(rw_flag), .busy(busy)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_rx[$];
   logic       exp_am[$];
   logic [7:0] last_rx = 8'h00;
   logic [7:0] tx_model = 8'h00;
   logic       cur_match = 1'b0;
   logic       cur_rd = 1'b0;
   logic       dut_drove = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT pulses an output.
   always @(negedge clk) begin
      logic [7:0] e;
      logic       r;
      if (rx_valid) begin
         if (exp_rx.size() == 0) chk("rx_valid_unexpected", 1, 0);
         else begin
            e = exp_rx.pop_front();
            chk("rx_data", rx_data, e);
         end
      end
      if (addr_match) begin
         if (exp_am.size() == 0) chk("addr_match_unexpected", 1, 0);
         else begin
            r = exp_am.pop_front();
            chk("rw_flag", rw_flag, r);
            chk("busy_on_match", busy, 1);
         end
      end
      if (sda_bus === 1'b0 && !m_low) dut_drove = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bitc(input logic b, output logic s);
      m_low = ~b;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      s = sda_bus;
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic do_start();
      m_low = 1'b0;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_low = 1'b1;
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic do_stop();
      m_low = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_low = 1'b0;
      tick(Q + 1);
      chk("busy_after_stop", busy, 0);
   endtask

   task automatic addr_bits(input logic [6:0] a, input logic rw);
      logic [7:0] v;
      logic       s;
      v = {a, rw};
      cur_match = (a == DEV);
      cur_rd = rw;
      if (cur_match) exp_am.push_back(rw);
      if (cur_match && rw) tx_model = tx_data;
      for (int i = 7; i >= 0; i--) bitc(v[i], s);
   endtask

   task automatic send_addr(input logic [6:0] a, input logic rw);
      logic s;
      addr_bits(a, rw);
      bitc(1'b1, s);
      chk("addr_ack", s, cur_match ? 0 : 1);
   endtask

   task automatic wr_byte(input logic [7:0] d);
      logic s;
      if (cur_match) begin
         exp_rx.push_back(d);
         last_rx = d;
      end
      for (int i = 7; i >= 0; i--) bitc(d[i], s);
      bitc(1'b1, s);
      chk("write_ack", s, cur_match ? 0 : 1);
   endtask

   task automatic rd_byte(input logic mnack, input logic [7:0] nxt);
      logic [7:0] got;
      logic [7:0] exp;
      logic       s;
      exp = (cur_match && cur_rd) ? tx_model : 8'hFF;
      for (int i = 7; i >= 0; i--) begin
         bitc(1'b1, s);
         got[i] = s;
         if (i == 4) tx_data = 8'($urandom);
      end
      tx_data = nxt;
      if (!mnack) tx_model = nxt;
      bitc(mnack, s);
      chk("read_byte", got, exp);
      if (mnack) begin
         chk("ack_slot_released", s, 1);
         cur_match = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, limit reached");
      $fatal(1);
   end

   initial begin
      logic [6:0] a;
      logic       rw;
      logic       m;
      int         n;
      #1;
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_addr_match", addr_match, 0);
      chk("rst_rw_flag", rw_flag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sda_released", sda_bus, 1);
      tick(4);
      rst = 1'b0;
      tick(4);

      // Write match
      do_start(); send_addr(DEV, 1'b0); wr_byte(8'hA5); do_stop();

      // Address mismatch
      dut_drove = 1'b0;
      do_start(); send_addr(7'h43, 1'b0); wr_byte(8'h11); do_stop();
      chk("mismatch_silent", dut_drove, 0);
      chk("mismatch_rx_kept", rx_data, 8'hA5);

      // Read with NACK, then clock another byte to see the block stays silent
      tx_data = 8'h3C;
      do_start(); send_addr(DEV, 1'b1); rd_byte(1'b1, 8'h99); rd_byte(1'b1, 8'h77); do_stop();

      // Two-byte read: tx_data changes before the master ACK
      tx_data = 8'h3C;
      do_start(); send_addr(DEV, 1'b1); rd_byte(1'b0, 8'hC3); rd_byte(1'b1, 8'h00); do_stop();

      // Repeated START
      do_start(); send_addr(DEV, 1'b0); wr_byte(8'h55);
      tx_data = 8'h81;
      do_start(); send_addr(DEV, 1'b1); rd_byte(1'b1, 8'h00);
      chk("rep_start_rx", rx_data, 8'h55);
      chk("rep_start_rw", rw_flag, 1);
      do_stop();

      // Reset while the address ACK is driven
      do_start(); addr_bits(DEV, 1'b0);
      m_low = 1'b0;
      tick(1);
      chk("ack_driven_low", sda_bus, 0);
      rst = 1'b1;
      #1;
      chk("rst_mid_ack_release", sda_bus, 1);
      chk("rst_mid_ack_busy", busy, 0);
      chk("rst_mid_ack_rx", rx_data, 0);
      last_rx = 8'h00;
      tick(2);
      rst = 1'b0;
      tick(2);
      scl = 1'b1;
      tick(2 * Q);
      do_start(); send_addr(DEV, 1'b0); wr_byte(8'h0F); do_stop();

      // Randomized transactions
      for (int t = 0; t < 16; t++) begin
         m  = ($urandom_range(0, 3) != 0);
         a  = m ? DEV : 7'(DEV + 7'($urandom_range(1, 126)));
         rw = 1'($urandom);
         n  = $urandom_range(1, 3);
         dut_drove = 1'b0;
         if (rw) tx_data = 8'($urandom);
         do_start();
         send_addr(a, rw);
         for (int k = 0; k < n; k++) begin
            if (rw) rd_byte((k == n - 1), 8'($urandom));
            else    wr_byte(8'($urandom));
         end
         do_stop();
         if (!m) begin
            chk("rand_mismatch_silent", dut_drove, 0);
            chk("rand_mismatch_rx_kept", rx_data, last_rx);
         end
      end

      tick(4);
      chk("rx_queue_drained", exp_rx.size(), 0);
      chk("am_queue_drained", exp_am.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
